// File: rtl/proximity_event_filter_pkg.sv
// Shared definitions for the presence filter: FSM encoding and 50 MHz defaults.
package proximity_event_filter_pkg;

  typedef enum logic [1:0] {
    ABSENT      = 2'd0,
    CONFIRM_ON  = 2'd1,
    PRESENT     = 2'd2,
    CONFIRM_OFF = 2'd3
  } pef_state_e;

  localparam int DEF_ON_CYCLES   = 5_000_000;
  localparam int DEF_OFF_CYCLES  = 25_000_000;
  localparam int DEF_TICK_CYCLES = 50_000_000;
  localparam int DEF_CNT_W       = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/proximity_event_filter_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (presence flag, echo).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/proximity_event_filter.sv
// Debounces the ultrasonic presence flag into approach/leave events, an approach
// counter and a dwell-seconds measurement.
module proximity_event_filter
  import proximity_event_filter_pkg::*;
#(
  parameter int ON_CYCLES   = DEF_ON_CYCLES,
  parameter int OFF_CYCLES  = DEF_OFF_CYCLES,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_in,
  input  logic             clr_count,
  output logic             near,
  output logic             approach,
  output logic             leave,
  output logic [CNT_W-1:0] approach_count,
  output logic [CNT_W-1:0] dwell_s
);

  localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
  localparam int KW = $clog2(TICK_CYCLES + 1);

  localparam logic [TW-1:0]    T_ONE     = TW'(1);
  localparam logic [TW-1:0]    ON_T      = TW'(ON_CYCLES);
  localparam logic [TW-1:0]    OFF_T     = TW'(OFF_CYCLES);
  localparam logic [KW-1:0]    TICK_LAST = KW'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic          s;
  pef_state_e    st;
  logic [TW-1:0] timer;
  logic [KW-1:0] tick;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (state_in),
    .q     (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= ABSENT;
      timer          <= '0;
      tick           <= '0;
      near           <= 1'b0;
      approach       <= 1'b0;
      leave          <= 1'b0;
      approach_count <= '0;
      dwell_s        <= '0;
    end else begin
      approach <= 1'b0;
      leave    <= 1'b0;
      if (clr_count) approach_count <= '0;

      // Dwell keeps running through the off-confirmation window so short gaps
      // don't interrupt it; the approach branch below overrides the restart.
      if (st == PRESENT || st == CONFIRM_OFF) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          if (dwell_s != CNT_MAX) dwell_s <= dwell_s + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end

      case (st)
        ABSENT: begin
          if (s) begin
            st    <= CONFIRM_ON;
            timer <= T_ONE;
          end
        end
        CONFIRM_ON: begin
          if (!s) begin
            st    <= ABSENT;
            timer <= '0;
          end else if (timer == ON_T) begin
            st       <= PRESENT;
            timer    <= '0;
            near     <= 1'b1;
            approach <= 1'b1;
            dwell_s  <= '0;
            tick     <= '0;
            if (clr_count)                    approach_count <= CNT_ONE;
            else if (approach_count != CNT_MAX) approach_count <= approach_count + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PRESENT: begin
          if (!s) begin
            st    <= CONFIRM_OFF;
            timer <= T_ONE;
          end
        end
        CONFIRM_OFF: begin
          if (s) begin
            st    <= PRESENT;
            timer <= '0;
          end else if (timer == OFF_T) begin
            st    <= ABSENT;
            timer <= '0;
            near  <= 1'b0;
            leave <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          st    <= ABSENT;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proximity_event_filter.sv
// Scoreboard bench: stimulus pushes expected approach/leave events, a monitor
// pops and compares them whenever the DUT pulses.
module tb_proximity_event_filter;

  localparam int ON   = 4;
  localparam int OFF  = 6;
  localparam int TICK = 10;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          state_in = 1'b0;
  logic          clr_count = 1'b0;
  logic          near, approach, leave;
  logic [CW-1:0] approach_count, dwell_s;

  typedef struct {
    bit is_leave;
    int cyc;
    int cnt;
    int dwell;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  exp_cnt = 0;

  proximity_event_filter #(
    .ON_CYCLES   (ON),
    .OFF_CYCLES  (OFF),
    .TICK_CYCLES (TICK),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .state_in       (state_in),
    .clr_count      (clr_count),
    .near           (near),
    .approach       (approach),
    .leave          (leave),
    .approach_count (approach_count),
    .dwell_s        (dwell_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(posedge clk) begin
    #1;
    if (reset && (approach || leave)) begin
      chk("no_simultaneous_pulses", int'(approach && leave), 0);
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_kind_leave", int'(leave), int'(e.is_leave));
        chk("event_cycle", cyc, e.cyc);
        chk("event_near", int'(near), int'(!e.is_leave));
        chk("event_count", int'(approach_count), e.cnt);
        chk("event_dwell", int'(dwell_s), e.dwell);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise state_in; approach expected ON+2 edges after first sampling edge.
  task automatic go_high(input bit clr, output int a);
    ev_t e;
    @(negedge clk);
    state_in = 1'b1;
    a = cyc + 1 + ON + 2;
    exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
    e.is_leave = 1'b0; e.cyc = a; e.cnt = exp_cnt; e.dwell = 0;
    q.push_back(e);
    if (clr) begin
      wait_edge(a - 1);
      clr_count = 1'b1;
      wait_edge(a);
      clr_count = 1'b0;
    end
  endtask

  // Drop state_in; leave expected OFF+2 edges later, dwell = whole ticks since approach.
  task automatic go_low(input int a, output int l);
    ev_t e;
    int d;
    @(negedge clk);
    state_in = 1'b0;
    l = cyc + 1 + OFF + 2;
    d = (l - a) / TICK;
    e.is_leave = 1'b1; e.cyc = l; e.cnt = exp_cnt; e.dwell = (d > 255) ? 255 : d;
    q.push_back(e);
  endtask

  initial begin
    int a, l, k;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_near", int'(near), 0);
    chk("rst_approach", int'(approach), 0);
    chk("rst_leave", int'(leave), 0);
    chk("rst_count", int'(approach_count), 0);
    chk("rst_dwell", int'(dwell_s), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // First approach, held 35 cycles, then drop
    go_high(1'b0, a);
    wait_edge(a + 1);
    chk("approach_one_cycle", int'(approach), 0);
    chk("near_held", int'(near), 1);
    wait_edge(a + 34);
    go_low(a, l);
    wait_edge(a + 35);
    chk("dwell_at_drop", int'(dwell_s), 3);
    wait_edge(a + 40);
    chk("dwell_in_confirm_off", int'(dwell_s), 4);
    chk("near_in_confirm_off", int'(near), 1);
    wait_edge(l + 15);
    chk("dwell_frozen", int'(dwell_s), 4);
    chk("near_after_leave", int'(near), 0);

    // 3-cycle glitch while absent
    @(negedge clk);
    state_in = 1'b1;
    repeat (3) @(negedge clk);
    state_in = 1'b0;
    wait_edge(cyc + 15);
    chk("glitch_near", int'(near), 0);
    chk("glitch_count", int'(approach_count), exp_cnt);

    // 4-cycle gap during presence
    go_high(1'b0, a);
    wait_edge(a + 12);
    chk("gap_dwell_before", int'(dwell_s), 1);
    @(negedge clk);
    state_in = 1'b0;
    repeat (4) @(negedge clk);
    state_in = 1'b1;
    wait_edge(a + 30);
    chk("gap_near", int'(near), 1);
    chk("gap_dwell_mid", int'(dwell_s), 3);
    wait_edge(a + 41);
    chk("gap_dwell_after", int'(dwell_s), 4);
    go_low(a, l);
    wait_edge(l + 2);

    // Saturation of approach_count
    for (int i = 0; i < 260; i++) begin
      go_high(1'b0, a);
      wait_edge(a + 1);
      go_low(a, l);
      wait_edge(l + 1);
    end
    chk("count_saturated", int'(approach_count), 255);

    // clr_count coinciding with an approach
    go_high(1'b1, a);
    wait_edge(a + 1);
    chk("clr_on_approach", int'(approach_count), 1);

    // Reset during CONFIRM_OFF
    @(negedge clk);
    state_in = 1'b0;
    k = cyc + 1;
    wait_edge(k + 4);
    chk("pre_reset_near", int'(near), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_near", int'(near), 0);
    chk("midrst_leave", int'(leave), 0);
    chk("midrst_count", int'(approach_count), 0);
    chk("midrst_dwell", int'(dwell_s), 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_edge(cyc + 20);
    chk("post_rst_near", int'(near), 0);
    chk("post_rst_count", int'(approach_count), 0);

    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      chk("missing_event_at_cycle", 0, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
